// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_exec_unit_if : request/response bundle between operand read and ALU
// Revision: 1.0
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUControl;
  logic [1:0]       FlagW;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;

  modport master (
    output in_valid, ALUControl, FlagW, SrcA, SrcB, shamt, out_ready,
    input  in_ready, out_valid, Result, ALUFlags
  );

  modport slave (
    input  in_valid, ALUControl, FlagW, SrcA, SrcB, shamt, out_ready,
    output in_ready, out_valid, Result, ALUFlags
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_exec_unit : single-cycle add/sub/logic, bit-serial shifts, NZCV flags
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic         clk,
  input  logic         reset,
  alu_exec_unit_if.slave bus
);

  localparam logic [3:0] C_OP_ADD = 4'b0000;
  localparam logic [3:0] C_OP_SUB = 4'b0001;
  localparam logic [3:0] C_OP_AND = 4'b0010;
  localparam logic [3:0] C_OP_ORR = 4'b0011;
  localparam logic [3:0] C_OP_XOR = 4'b0100;
  localparam logic [3:0] C_OP_NOT = 4'b0101;
  localparam logic [3:0] C_OP_LSL = 4'b0111;
  localparam logic [3:0] C_OP_LSR = 4'b1000;
  localparam logic [3:0] C_OP_ASR = 4'b1001;

  localparam logic [WIDTH:0] C_ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] sh_q;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       op_q;
  logic [1:0]       flagw_q;

  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_c_d;
  logic             alu_v_d;
  logic             alu_legal_d;
  logic             alu_shift_d;
  logic [WIDTH-1:0] sh_d;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.ALUFlags  = flags_q;

  // Single-cycle datapath, evaluated on the live request operands.
  always_comb begin
    sum_d       = '0;
    alu_res_d   = '0;
    alu_c_d     = 1'b0;
    alu_v_d     = 1'b0;
    alu_legal_d = 1'b1;
    alu_shift_d = 1'b0;
    case (bus.ALUControl)
      C_OP_ADD: begin
        sum_d     = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
        alu_res_d = sum_d[WIDTH-1:0];
        alu_c_d   = sum_d[WIDTH];
        alu_v_d   = (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1]) &&
                    (alu_res_d[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      C_OP_SUB: begin
        sum_d     = {1'b0, bus.SrcA} + {1'b0, ~bus.SrcB} + C_ONE;
        alu_res_d = sum_d[WIDTH-1:0];
        alu_c_d   = sum_d[WIDTH];
        alu_v_d   = (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1]) &&
                    (alu_res_d[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      C_OP_AND: alu_res_d = bus.SrcA & bus.SrcB;
      C_OP_ORR: alu_res_d = bus.SrcA | bus.SrcB;
      C_OP_XOR: alu_res_d = bus.SrcA ^ bus.SrcB;
      C_OP_NOT: alu_res_d = ~bus.SrcB;
      C_OP_LSL, C_OP_LSR, C_OP_ASR: begin
        // A zero-length shift completes immediately with the operand unchanged.
        alu_res_d   = bus.SrcB;
        alu_shift_d = 1'b1;
      end
      default: alu_legal_d = 1'b0;
    endcase
  end

  // One-bit shift step applied to the working register.
  always_comb begin
    sh_d = sh_q;
    case (op_q)
      C_OP_LSL: sh_d = {sh_q[WIDTH-2:0], 1'b0};
      C_OP_LSR: sh_d = {1'b0, sh_q[WIDTH-1:1]};
      default:  sh_d = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    endcase
  end

  function automatic logic [3:0] merge_flags(
    input logic [WIDTH-1:0] r,
    input logic             c,
    input logic             v,
    input logic [1:0]       fw,
    input logic [3:0]       prev
  );
    logic [3:0] f;
    f = prev;
    if (fw[1]) begin
      f[3] = r[WIDTH-1];
      f[2] = (r == '0);
    end
    if (fw[0]) begin
      f[1] = c;
      f[0] = v;
    end
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      sh_q        <= '0;
      cnt_q       <= '0;
      op_q        <= 4'b0000;
      flagw_q     <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            if (alu_shift_d && (bus.shamt != '0)) begin
              sh_q    <= bus.SrcB;
              cnt_q   <= bus.shamt;
              op_q    <= bus.ALUControl;
              flagw_q <= bus.FlagW;
              state_q <= S_SHIFT;
            end else begin
              result_q <= alu_res_d;
              if (alu_legal_d) begin
                flags_q <= merge_flags(alu_res_d, alu_c_d, alu_v_d,
                                       bus.FlagW, flags_q);
              end
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_q    <= sh_d;
            flags_q     <= merge_flags(sh_d, 1'b0, 1'b0, flagw_q, flags_q);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the ALU control bundle: takes `ALUControl[3:0]` and `FlagW[1:0]` from the ALU decoder, executes the operation and holds the registered NZCV flags.
- Add, sub and logic ops complete in one cycle.
- Shifts run iteratively, one bit per cycle, through an internal shifter.
- Valid/ready handshake on both sides. Sits between the register-file read stage and writeback/condition logic.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHW, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept an operation; high only in IDLE.
- ALUControl  input  4  op: 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 XOR, 0101 NOT, 0111 LSL, 1000 LSR, 1001 ASR; others illegal.
- FlagW  input  2  bit1 enables N,Z update; bit0 enables C,V update.
- SrcA  input  WIDTH  first operand.
- SrcB  input  WIDTH  second operand, and the shifted operand for shifts.
- shamt  input  SHW  shift amount; ignored for non-shift ops.
- out_valid  output  1  Result valid; high only in DONE.
- out_ready  input  1  consumer accepts Result.
- Result  output  WIDTH  registered result.
- ALUFlags  output  4  registered {N,Z,C,V}.

Behaviour:
- Reset (synchronous, highest priority, any state including mid-shift):
  - state=IDLE, Result=0, ALUFlags=0000, out_valid=0, in_ready=1.
  - Internal shift count=0.
  - Any in-flight operation is discarded.
- FSM IDLE -> SHIFT -> DONE -> IDLE, with handshake rules:
  - in_ready = (state==IDLE); out_valid = (state==DONE).
  - Inputs are sampled only on the accept cycle (in_valid & in_ready).
  - After accept, SrcA/SrcB/ALUControl/FlagW/shamt may change freely.
- IDLE, accept of a non-shift op:
  - Compute the result combinationally and register it into Result.
  - Update the enabled flags; go to DONE.
  - Latency: out_valid rises on the first clock edge after the accept edge.
- IDLE, accept of a shift op with shamt==0:
  - Result=SrcB; go directly to DONE (same latency as non-shift).
- IDLE, accept of a shift op with shamt!=0:
  - Load shift register with SrcB, count=shamt, latch op and FlagW; go to SHIFT.
- SHIFT:
  - Each cycle shift by one bit and decrement count:
    - LSL inserts 0 at LSB.
    - LSR inserts 0 at MSB.
    - ASR replicates the MSB.
  - When count reaches 0, register the final value to Result, update flags, go to DONE.
  - Total latency: shamt+1 edges from accept to out_valid.
  - shamt=31 with ASR of a negative operand yields all ones.
- DONE:
  - Result and ALUFlags are held stable while out_ready=0.
  - out_ready=1 -> IDLE on the next edge.
  - No new accept in the same cycle as output handoff; minimum issue interval is 2 cycles.
- Arithmetic:
  - ADD: {C,Result} = SrcA+SrcB; V = (A[31]==B[31]) & (R[31]!=A[31]).
  - SUB: Result = SrcA-SrcB, computed as A + ~B + 1.
    - C = carry out (1 = no borrow, i.e. SrcA >= SrcB unsigned).
    - V = (A[31]!=B[31]) & (R[31]!=A[31]).
  - AND/ORR/XOR bitwise; NOT: Result = ~SrcB.
  - Logic ops and shifts produce C=0, V=0 candidates.
  - N = Result[WIDTH-1]; Z = (Result==0).
- Flag write:
  - Flags are written only at the edge that enters DONE.
  - FlagW[1] writes N,Z; FlagW[0] writes C,V; unenabled flags hold their previous value.
- Illegal ALUControl:
  - Accepted, Result=0, flags unchanged regardless of FlagW.
  - Goes to DONE with normal 1-cycle latency.
- Simultaneous events:
  - reset overrides accept and handoff.
  - in_valid while not IDLE is ignored; the request must be held by the producer.

Test Plan:
- Reset then ADD, FlagW=11, A=0xFFFFFFFF, B=0x00000001 -> next cycle out_valid=1, Result=0x00000000, ALUFlags=0110 (Z=1, C=1, N=0, V=0).
- SUB, FlagW=11, A=0x80000000, B=0x00000001 -> Result=0x7FFFFFFF, ALUFlags=0011 (C=1 no borrow, V=1); then AND with FlagW=00 leaves ALUFlags=0011.
- ASR, FlagW=10, SrcB=0x80000000, shamt=4, with prior C=1,V=1 -> out_valid exactly 5 edges after accept, Result=0xF8000000, ALUFlags=1011 (N=1, Z=0, C/V held).
- LSL shamt=0, SrcB=0x12345678 -> Result=0x12345678 after 1 cycle; hold out_ready=0 for 3 cycles -> Result/out_valid stable, in_ready=0; in_valid pulses in this window are ignored.
- Reset asserted during the 3rd SHIFT cycle of LSR shamt=10 -> next edge: IDLE, in_ready=1, out_valid=0, Result=0, ALUFlags=0000.
- Illegal ALUControl=1111, FlagW=11 after flags=1000 -> Result=0, ALUFlags stays 1000, out_valid after 1 cycle.
